// File: rtl/uart_trx.sv
// rtl/uart_trx.sv - full-duplex UART transmitter/receiver with runtime parity, stop-bit and prescale config
// Optional macro UART_TRX_LOOPBACK_EN adds a LOOPBACK input that routes the TX line into the RX path.
module uart_trx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     TX_IN_P,
  input  logic                      TX_IN_V,
  input  logic                      RX_IN_S,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
`ifdef UART_TRX_LOOPBACK_EN
  input  logic                      LOOPBACK,
`endif
  output logic                      TX_OUT_S,
  output logic                      TX_BUSY,
  output logic [DATA_WIDTH-1:0]     RX_OUT_P,
  output logic                      RX_OUT_V,
  output logic                      PAR_ERR,
  output logic                      FRM_ERR
);

  localparam int PW = PRESCALE_WIDTH;
  localparam int BW = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [PW-1:0] pre_eff;
  assign pre_eff = (Prescale < PW'(8)) ? PW'(8) : Prescale;

  state_e                tx_state_q, tx_state_d;
  logic [PW-1:0]         tx_cnt_q, tx_cnt_d, tx_pre_q, tx_pre_d;
  logic [BW-1:0]         tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_par_en_q, tx_par_en_d, tx_stop2_q, tx_stop2_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_last, tx_serial;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_q  <= IDLE;
      tx_cnt_q    <= '0;
      tx_pre_q    <= PW'(8);
      tx_bit_q    <= '0;
      tx_data_q   <= '0;
      tx_par_en_q <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_par_q    <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_pre_q    <= tx_pre_d;
      tx_bit_q    <= tx_bit_d;
      tx_data_q   <= tx_data_d;
      tx_par_en_q <= tx_par_en_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_par_q    <= tx_par_d;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = '0;
    tx_pre_d    = tx_pre_q;
    tx_bit_d    = tx_bit_q;
    tx_data_d   = tx_data_q;
    tx_par_en_d = tx_par_en_q;
    tx_stop2_d  = tx_stop2_q;
    tx_par_d    = tx_par_q;
    tx_last     = (tx_cnt_q == tx_pre_q - PW'(1));
    if (tx_state_q != IDLE && !tx_last) tx_cnt_d = tx_cnt_q + PW'(1);
    case (tx_state_q)
      IDLE: begin
        if (TX_IN_V) begin
          tx_state_d  = START;
          tx_bit_d    = '0;
          tx_data_d   = TX_IN_P;
          tx_pre_d    = pre_eff;
          tx_par_en_d = PAR_EN;
          tx_stop2_d  = STOP2;
          tx_par_d    = (^TX_IN_P) ^ PAR_TYP;
        end
      end
      START: if (tx_last) tx_state_d = DATA;
      DATA: begin
        // Data shifts out of bit 0 so the line never needs a variable bit select.
        if (tx_last) begin
          tx_data_d = tx_data_q >> 1;
          if (tx_bit_q == BW'(DATA_WIDTH - 1)) begin
            tx_bit_d   = '0;
            tx_state_d = tx_par_en_q ? PARITY : STOP;
          end else begin
            tx_bit_d = tx_bit_q + BW'(1);
          end
        end
      end
      PARITY: if (tx_last) tx_state_d = STOP;
      STOP: begin
        if (tx_last) begin
          if (tx_stop2_q && tx_bit_q == '0) tx_bit_d = BW'(1);
          else tx_state_d = IDLE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_serial = 1'b1;
    case (tx_state_q)
      START:   tx_serial = 1'b0;
      DATA:    tx_serial = tx_data_q[0];
      PARITY:  tx_serial = tx_par_q;
      default: tx_serial = 1'b1;
    endcase
  end

  assign TX_OUT_S = tx_serial;
  assign TX_BUSY  = (tx_state_q != IDLE);

  logic rx_in_sel;
`ifdef UART_TRX_LOOPBACK_EN
  assign rx_in_sel = LOOPBACK ? tx_serial : RX_IN_S;
`else
  assign rx_in_sel = RX_IN_S;
`endif

  state_e                rx_state_q, rx_state_d;
  logic [1:0]            rx_sync_q;
  logic                  rx_prev_q;
  logic [PW-1:0]         rx_cnt_q, rx_cnt_d, rx_pre_q, rx_pre_d;
  logic [BW-1:0]         rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d, rx_out_p_q, rx_out_p_d;
  logic                  rx_par_en_q, rx_par_en_d, rx_par_typ_q, rx_par_typ_d;
  logic                  rx_par_bit_q, rx_par_bit_d, rx_s0_q, rx_s0_d, rx_s1_q, rx_s1_d;
  logic                  rx_out_v_q, rx_out_v_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                  rx_s, rx_fall, rx_last, smp_a, smp_b, smp_c, maj, par_bad;
  logic [PW-1:0]         half;

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;
  assign rx_last = (rx_cnt_q == rx_pre_q - PW'(1));
  assign half    = rx_pre_q >> 1;
  assign smp_a   = (rx_cnt_q == half - PW'(1));
  assign smp_b   = (rx_cnt_q == half);
  assign smp_c   = (rx_cnt_q == half + PW'(1));
  assign maj     = (rx_s0_q & rx_s1_q) | (rx_s0_q & rx_s) | (rx_s1_q & rx_s);
  assign par_bad = rx_par_en_q & (rx_par_bit_q != ((^rx_data_q) ^ rx_par_typ_q));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_sync_q    <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= IDLE;
      rx_cnt_q     <= '0;
      rx_pre_q     <= PW'(8);
      rx_bit_q     <= '0;
      rx_data_q    <= '0;
      rx_out_p_q   <= '0;
      rx_par_en_q  <= 1'b0;
      rx_par_typ_q <= 1'b0;
      rx_par_bit_q <= 1'b0;
      rx_s0_q      <= 1'b1;
      rx_s1_q      <= 1'b1;
      rx_out_v_q   <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
    end else begin
      rx_sync_q    <= {rx_sync_q[0], rx_in_sel};
      rx_prev_q    <= rx_s;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_pre_q     <= rx_pre_d;
      rx_bit_q     <= rx_bit_d;
      rx_data_q    <= rx_data_d;
      rx_out_p_q   <= rx_out_p_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_par_typ_q <= rx_par_typ_d;
      rx_par_bit_q <= rx_par_bit_d;
      rx_s0_q      <= rx_s0_d;
      rx_s1_q      <= rx_s1_d;
      rx_out_v_q   <= rx_out_v_d;
      par_err_q    <= par_err_d;
      frm_err_q    <= frm_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = (rx_state_q == IDLE || rx_last) ? '0 : rx_cnt_q + PW'(1);
    rx_pre_d     = rx_pre_q;
    rx_bit_d     = rx_bit_q;
    rx_data_d    = rx_data_q;
    rx_out_p_d   = rx_out_p_q;
    rx_par_en_d  = rx_par_en_q;
    rx_par_typ_d = rx_par_typ_q;
    rx_par_bit_d = rx_par_bit_q;
    rx_s0_d      = smp_a ? rx_s : rx_s0_q;
    rx_s1_d      = smp_b ? rx_s : rx_s1_q;
    rx_out_v_d   = 1'b0;
    par_err_d    = 1'b0;
    frm_err_d    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        // The edge-detect cycle is bit-relative count 0, so the next cycle is count 1.
        if (rx_fall) begin
          rx_state_d   = START;
          rx_cnt_d     = PW'(1);
          rx_bit_d     = '0;
          rx_pre_d     = pre_eff;
          rx_par_en_d  = PAR_EN;
          rx_par_typ_d = PAR_TYP;
        end
      end
      START: begin
        if (smp_c && maj) begin
          rx_state_d = IDLE;
          rx_cnt_d   = '0;
        end else if (rx_last) begin
          rx_state_d = DATA;
        end
      end
      DATA: begin
        if (smp_c) rx_data_d = {maj, rx_data_q[DATA_WIDTH-1:1]};
        if (rx_last) begin
          if (rx_bit_q == BW'(DATA_WIDTH - 1)) begin
            rx_bit_d   = '0;
            rx_state_d = rx_par_en_q ? PARITY : STOP;
          end else begin
            rx_bit_d = rx_bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (smp_c) rx_par_bit_d = maj;
        if (rx_last) rx_state_d = STOP;
      end
      STOP: begin
        // Leave mid stop bit so a start edge immediately after it is still seen.
        if (smp_c) begin
          rx_state_d = IDLE;
          rx_cnt_d   = '0;
          par_err_d  = par_bad;
          frm_err_d  = ~maj;
          if (maj && !par_bad) begin
            rx_out_p_d = rx_data_q;
            rx_out_v_d = 1'b1;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  assign RX_OUT_P = rx_out_p_q;
  assign RX_OUT_V = rx_out_v_q;
  assign PAR_ERR  = par_err_q;
  assign FRM_ERR  = frm_err_q;

endmodule

// File: tb/tb_uart_trx.sv
// tb/tb_uart_trx.sv - scoreboard bench for uart_trx: queued TX frame and RX event expectations
// Define UART_TRX_LOOPBACK_EN to include the loopback case.
module tb_uart_trx;

  logic       CLK;
  logic       RST;
  logic [7:0] TX_IN_P;
  logic       TX_IN_V;
  logic       RX_IN_S;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic [5:0] Prescale;
`ifdef UART_TRX_LOOPBACK_EN
  logic       LOOPBACK;
`endif
  logic       TX_OUT_S;
  logic       TX_BUSY;
  logic [7:0] RX_OUT_P;
  logic       RX_OUT_V;
  logic       PAR_ERR;
  logic       FRM_ERR;

  uart_trx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK),
    .RST(RST),
    .TX_IN_P(TX_IN_P),
    .TX_IN_V(TX_IN_V),
    .RX_IN_S(RX_IN_S),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .STOP2(STOP2),
    .Prescale(Prescale),
`ifdef UART_TRX_LOOPBACK_EN
    .LOOPBACK(LOOPBACK),
`endif
    .TX_OUT_S(TX_OUT_S),
    .TX_BUSY(TX_BUSY),
    .RX_OUT_P(RX_OUT_P),
    .RX_OUT_V(RX_OUT_V),
    .PAR_ERR(PAR_ERR),
    .FRM_ERR(FRM_ERR)
  );

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          p;
    bit          abort;
  } tx_exp_t;

  typedef struct {
    logic [2:0] flags;
    logic [7:0] data;
  } rx_exp_t;

  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];
  int      n_checks = 0;
  int      n_errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tx_expect(input logic [15:0] bits, input int nbits, input int p, input bit abort);
    tx_exp_t e;
    e.bits  = bits;
    e.nbits = nbits;
    e.p     = p;
    e.abort = abort;
    tx_q.push_back(e);
  endtask

  task automatic rx_expect(input logic [2:0] flags, input logic [7:0] data);
    rx_exp_t r;
    r.flags = flags;
    r.data  = data;
    rx_q.push_back(r);
  endtask

  task automatic tx_send(input logic [7:0] d);
    TX_IN_P = d;
    TX_IN_V = 1'b1;
    @(negedge CLK);
    TX_IN_V = 1'b0;
  endtask

  task automatic rx_send(input logic [15:0] bits, input int n, input int p);
    for (int i = 0; i < n; i++) begin
      RX_IN_S = bits[i];
      repeat (p) @(negedge CLK);
    end
    RX_IN_S = 1'b1;
  endtask

  task automatic wait_busy(input logic level, input int budget);
    int k;
    k = 0;
    while (TX_BUSY !== level && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check(TX_BUSY === level, "wait_tx_busy", 32'(TX_BUSY), 32'(level));
  endtask

  initial begin : tx_mon
    tx_exp_t e;
    logic    bad;
    logic [1:0] seen;
    int      k;
    forever begin
      @(negedge CLK);
      if (TX_BUSY === 1'b1 && !RST) begin
        check(tx_q.size() > 0, "tx_frame_expected", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() == 0) begin
          k = 0;
          while (TX_BUSY === 1'b1 && k < 2000) begin @(negedge CLK); k++; end
        end else begin
          e = tx_q.pop_front();
          if (e.abort) begin
            k = 0;
            while (TX_BUSY === 1'b1 && k < 200) begin @(negedge CLK); k++; end
            check(TX_BUSY === 1'b0, "tx_abort_idle", 32'(TX_BUSY), 32'd0);
          end else begin
            for (int i = 0; i < e.nbits; i++) begin
              bad  = 1'b0;
              seen = {1'b1, e.bits[i]};
              for (int c = 0; c < e.p; c++) begin
                if (!bad && (TX_OUT_S !== e.bits[i] || TX_BUSY !== 1'b1)) begin
                  bad  = 1'b1;
                  seen = {TX_BUSY, TX_OUT_S};
                end
                @(negedge CLK);
              end
              check(!bad, $sformatf("tx_bit%0d", i), 32'(seen), 32'({1'b1, e.bits[i]}));
            end
            check(TX_BUSY === 1'b0, "tx_busy_end", 32'(TX_BUSY), 32'd0);
          end
        end
      end
    end
  end

  initial begin : rx_mon
    rx_exp_t r;
    forever begin
      @(negedge CLK);
      if (RX_OUT_V === 1'b1 || PAR_ERR === 1'b1 || FRM_ERR === 1'b1) begin
        check(rx_q.size() > 0, "rx_event_expected", 32'({RX_OUT_V, PAR_ERR, FRM_ERR}), 32'd0);
        if (rx_q.size() > 0) begin
          r = rx_q.pop_front();
          check({RX_OUT_V, PAR_ERR, FRM_ERR} === r.flags, "rx_flags",
                32'({RX_OUT_V, PAR_ERR, FRM_ERR}), 32'(r.flags));
          check(RX_OUT_P === r.data, "rx_data", 32'(RX_OUT_P), 32'(r.data));
        end
      end
    end
  end

  initial begin : watchdog
    repeat (30000) @(posedge CLK);
    n_errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : stim
    int k;
    RST      = 1'b1;
    TX_IN_V  = 1'b0;
    TX_IN_P  = 8'h00;
    RX_IN_S  = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    STOP2    = 1'b0;
    Prescale = 6'd8;
`ifdef UART_TRX_LOOPBACK_EN
    LOOPBACK = 1'b0;
`endif
    #7;
    check(TX_OUT_S === 1'b1, "rst_tx_out", 32'(TX_OUT_S), 32'd1);
    check(TX_BUSY === 1'b0, "rst_tx_busy", 32'(TX_BUSY), 32'd0);
    check(RX_OUT_P === 8'h00, "rst_rx_out_p", 32'(RX_OUT_P), 32'd0);
    check(RX_OUT_V === 1'b0, "rst_rx_out_v", 32'(RX_OUT_V), 32'd0);
    check(PAR_ERR === 1'b0, "rst_par_err", 32'(PAR_ERR), 32'd0);
    check(FRM_ERR === 1'b0, "rst_frm_err", 32'(FRM_ERR), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // 0xA5 even parity, one stop: TX and RX concurrently; mid-frame request/config changes ignored
    PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 6'd8;
    tx_expect(16'b00000_10101001010, 11, 8, 1'b0);
    rx_expect(3'b100, 8'hA5);
    fork
      begin
        tx_send(8'hA5);
        repeat (18) @(negedge CLK);
        TX_IN_P = 8'hFF; TX_IN_V = 1'b1; PAR_EN = 1'b0; STOP2 = 1'b1; Prescale = 6'd12;
        @(negedge CLK);
        TX_IN_V = 1'b0;
        repeat (30) @(negedge CLK);
        PAR_EN = 1'b1; STOP2 = 1'b0; Prescale = 6'd8;
      end
      begin
        repeat (3) @(negedge CLK);
        rx_send(16'b00000_10101001010, 11, 8);
      end
    join
    wait_busy(1'b0, 200);
    repeat (4) @(negedge CLK);

    rx_expect(3'b010, 8'hA5);
    rx_send(16'b00000_11101001010, 11, 8);
    repeat (16) @(negedge CLK);
    rx_expect(3'b001, 8'hA5);
    rx_send(16'b00000_00101001010, 11, 8);
    repeat (16) @(negedge CLK);
    rx_expect(3'b011, 8'hA5);
    rx_send(16'b00000_01101001010, 11, 8);
    repeat (16) @(negedge CLK);

    Prescale = 6'd16;
    RX_IN_S = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN_S = 1'b1;
    repeat (40) @(negedge CLK);

    PAR_TYP = 1'b1;
    rx_expect(3'b100, 8'h3C);
    rx_send(16'b00000_11001111000, 11, 16);
    repeat (20) @(negedge CLK);

    // No parity, Prescale 7 clamps to 8; two frames with no idle between them
    PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd7;
    rx_expect(3'b100, 8'h5A);
    rx_expect(3'b100, 8'hC3);
    rx_send(16'b000000_1010110100, 10, 8);
    rx_send(16'b000000_1110000110, 10, 8);
    repeat (16) @(negedge CLK);

    // Reset during TX data bit 3
    PAR_EN = 1'b1; Prescale = 6'd8;
    tx_expect(16'h0000, 0, 8, 1'b1);
    tx_send(8'hA5);
    repeat (34) @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    check(TX_OUT_S === 1'b1, "abort_tx_out", 32'(TX_OUT_S), 32'd1);
    check(TX_BUSY === 1'b0, "abort_tx_busy", 32'(TX_BUSY), 32'd0);
    check(RX_OUT_P === 8'h00, "abort_rx_out_p", 32'(RX_OUT_P), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // 0x3C odd parity, two stops, Prescale 5 clamps to 8; then back-to-back 0x01 no parity at 9
    PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b1; Prescale = 6'd5;
    tx_expect(16'b0000_111001111000, 12, 8, 1'b0);
    tx_expect(16'b000000_1000000010, 10, 9, 1'b0);
    tx_send(8'h3C);
    TX_IN_P = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 6'd9;
    repeat (10) @(negedge CLK);
    TX_IN_V = 1'b1;
    wait_busy(1'b0, 200);
    wait_busy(1'b1, 3);
    TX_IN_V = 1'b0;
    wait_busy(1'b0, 200);
    repeat (4) @(negedge CLK);

`ifdef UART_TRX_LOOPBACK_EN
    LOOPBACK = 1'b1;
    @(negedge CLK);
    RX_IN_S = 1'b0;
    PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b1; Prescale = 6'd16;
    tx_expect(16'b0000_111001111000, 12, 16, 1'b0);
    rx_expect(3'b100, 8'h3C);
    tx_send(8'h3C);
    wait_busy(1'b0, 400);
    repeat (8) @(negedge CLK);
    RX_IN_S = 1'b1;
    @(negedge CLK);
    LOOPBACK = 1'b0;
`endif

    k = 0;
    while ((TX_BUSY === 1'b1 || tx_q.size() != 0 || rx_q.size() != 0) && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    repeat (5) @(negedge CLK);
    check(tx_q.size() == 0, "tx_queue_drained", 32'(tx_q.size()), 32'd0);
    check(rx_q.size() == 0, "rx_queue_drained", 32'(rx_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
